char_serializer: RTL and testbench
==================================

Name: char_serializer

Overview:
- Downstream consumer of the character bus driven by the RAM read path.
- Accepts WORD_SIZE-bit characters on a valid/ready handshake and buffers them in a small FIFO.
- Sends each character as an asynchronous serial frame on a single `tx` line: start bit, WORD_SIZE data bits LSB-first, stop bit.
- Lets the memory read stream be observed or exported at a fixed bit rate, with backpressure to the reader.

Parameters:
- WORD_SIZE, 16, character width in bits; matches the RAM word size.
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be ≥ 1.
- FIFO_DEPTH, 4, input buffer entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  WORD_SIZE  character from the RAM bus.
- din_valid  in  1  din holds a character to accept.
- din_ready  out  1  block can accept a character this cycle.
- tx  out  1  serial output; idle high.
- busy  out  1  a frame is in progress (state != IDLE).
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - tx=1, busy=0, count=0, din_ready=1.
  - FIFO pointers cleared; FSM goes to IDLE; bit and cycle counters cleared.
  - A frame in flight is abandoned; tx returns high at once.
- Handshake:
  - din_ready = (count < FIFO_DEPTH), combinational from registered count.
  - Push occurs on an edge where din_valid && din_ready.
  - din_valid while din_ready=0 has no effect; the producer must hold din.
- Full FIFO: no bypass. din_ready stays low even on a cycle where a pop also happens.
- Simultaneous push and pop (not full): count unchanged; both take effect.
- count: +1 on push only, −1 on pop only. Never exceeds FIFO_DEPTH and never underflows; pops are only issued when count>0.
- FIFO is registered storage. A word pushed at edge N is visible to the FSM in cycle N+1.
- FSM states: IDLE, START, DATA, STOP. tx is driven from a register.
  - IDLE: tx=1. If count>0, pop the head into the shift register, clear counters, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment bit index. After bit WORD_SIZE−1 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - At the end, if count>0: pop and go straight to START (no idle gap).
    - Otherwise go to IDLE.
- Frame length is (WORD_SIZE+2)*CLKS_PER_BIT cycles; 72 at defaults.
- Latency: word pushed into an empty, idle block at edge N → popped at edge N+1 → tx low from edge N+2 (registered output).
- Back-to-back frames: consecutive frames abut exactly, 72 cycles apart at defaults.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy is tracked by count, so full and empty are unambiguous.
- Cycle counter width is $clog2(CLKS_PER_BIT)+1. CLKS_PER_BIT=1 must work: one cycle per bit.

Test Plan:
- Reset: assert rst_n=0 mid-run → tx=1, busy=0, count=0, din_ready=1 immediately, without waiting for a clock edge.
- Single char: push 0x0041 ('A') at edge 0, defaults → tx low edges 2–5.
  - Then bits 1,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0, each held 4 cycles.
  - Then stop high for 4 cycles; busy falls at edge 74.
- Back-to-back: push 0x0048 then 0x0069 on consecutive cycles.
  - Second start bit begins exactly 72 cycles after the first.
  - tx never idles between frames; total busy time is 144 cycles.
- Full/backpressure: hold din_valid=1 with a new word each accepted cycle from idle.
  - Words 0–4 are accepted at edges 0–4; count reaches 4 at edge 4; din_ready goes low.
  - Word 5 stalls until word 0's stop bit ends, then is accepted.
  - Serial output order is 0..5.
- Push and pop in the same cycle: at count=2, push exactly on the STOP→START pop edge → count stays 2; data order is preserved.
- Reset mid-frame: pulse rst_n low during DATA bit 7.
  - tx=1 at once; FIFO is empty afterwards.
  - A new push of 0x0030 after release transmits a clean, complete frame.

Source files
------------

// File: rtl/char_serializer.sv
// char_serializer: buffers WORD_SIZE-bit characters and sends each one as an async serial frame (start, LSB-first data, stop).
// Latency: a word pushed into an empty idle block at edge N is popped at N+1 and tx drops at N+2; frames are (WORD_SIZE+2)*CLKS_PER_BIT cycles.
// Backpressure: din_ready is low while the FIFO holds FIFO_DEPTH words, including on a cycle that also pops.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   din         - character from the RAM read bus
//   din_valid   - din holds a character to accept
//   din_ready   - a character can be accepted this cycle
//   tx          - serial line, idle high, registered
//   busy        - a frame is in progress, registered so it lines up with tx
//   count       - current FIFO occupancy
module char_serializer #(
  parameter int WORD_SIZE    = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORD_SIZE-1:0]        din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(WORD_SIZE) + 1;

  typedef logic [AW-1:0]        ptr_t;
  typedef logic [AW:0]          cnt_t;
  typedef logic [CW-1:0]        cyc_t;
  typedef logic [BW-1:0]        bit_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  localparam cnt_t FULL_CNT = cnt_t'(FIFO_DEPTH);
  localparam cyc_t LAST_CYC = cyc_t'(CLKS_PER_BIT - 1);
  localparam bit_t LAST_BIT = bit_t'(WORD_SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  word_t  mem [FIFO_DEPTH];
  ptr_t   wr_ptr, rd_ptr;
  state_t state, state_d;
  word_t  shift, shift_d;
  bit_t   bit_idx, bit_d;
  cyc_t   cyc, cyc_d;
  logic   tx_d;
  logic   push, pop;
  logic   last_cyc;

  // No bypass: a full FIFO refuses input even when the FSM pops that cycle.
  assign din_ready = (count < FULL_CNT);
  assign push      = din_valid && din_ready;

  always_comb begin
    state_d  = state;
    shift_d  = shift;
    bit_d    = bit_idx;
    cyc_d    = cyc;
    pop      = 1'b0;
    tx_d     = 1'b1;
    last_cyc = (cyc == LAST_CYC);
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          bit_d   = '0;
          cyc_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (last_cyc) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc + cyc_t'(1);
        end
      end
      DATA: begin
        tx_d = shift[0];
        if (last_cyc) begin
          cyc_d   = '0;
          shift_d = shift >> 1;
          if (bit_idx == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_idx + bit_t'(1);
          end
        end else begin
          cyc_d = cyc + cyc_t'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (last_cyc) begin
          cyc_d = '0;
          // Chain straight into the next start bit so queued frames abut.
          if (count != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc + cyc_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      cyc     <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
      state   <= state_d;
      shift   <= shift_d;
      bit_idx <= bit_d;
      cyc     <= cyc_d;
      tx      <= tx_d;
      // Registered from state so busy covers exactly the cycles tx spends in a frame.
      busy    <= (state != IDLE);
    end
  end

  // Character storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: tb/tb_char_serializer.sv
// tb_char_serializer: randomized and directed stimulus against a frame-timeline reference model.
// Latency: model predicts outputs after every clock edge; outputs sampled on the falling edge.
// Backpressure: bench only counts a push when its own model says the FIFO has room.
module tb_char_serializer;

  localparam int W   = 16;
  localparam int CPB = 4;
  localparam int D   = 4;
  localparam int FL  = (W + 2) * CPB;
  localparam int TN  = 1024;

  logic         clk, rst_n, din_valid, din_ready, tx, busy;
  logic [W-1:0] din;
  logic [2:0]   count;

  char_serializer #(.WORD_SIZE(W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .tx(tx), .busy(busy), .count(count)
  );

  int tests = 0;
  int fails = 0;
  int ecur  = 0;
  int last_s = -100000;
  int pe [$];
  int fs [$];
  logic [W-1:0] fd [$];
  logic trc [TN];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each accepted word becomes a frame whose first start-bit edge is
  // max(push_edge + 2, previous_start + FL); its pop happens one edge before that.
  function automatic int m_count(int e);
    int n = 0;
    foreach (pe[k]) if (pe[k] <= e) n++;
    foreach (fs[k]) if (fs[k] - 1 <= e) n--;
    return n;
  endfunction

  // Expected {tx, busy, din_ready, count} after edge e.
  function automatic logic [5:0] m_vec(int e);
    logic t = 1'b1;
    logic b = 1'b0;
    logic [W-1:0] w;
    int bi, n;
    foreach (fs[k]) begin
      if (e >= fs[k] && e < fs[k] + FL) begin
        b  = 1'b1;
        bi = (e - fs[k]) / CPB;
        w  = fd[k];
        if (bi == 0) t = 1'b0;
        else if (bi <= W) t = w[bi-1];
        else t = 1'b1;
      end
    end
    n = m_count(e);
    return {t, b, n < D, 3'(n)};
  endfunction

  task automatic clear_model();
    pe.delete();
    fs.delete();
    fd.delete();
    last_s = -100000;
  endtask

  task automatic clr_trc();
    foreach (trc[i]) trc[i] = 1'b1;
  endtask

  function automatic int find_low(int from);
    for (int i = from; i < TN; i++) if (trc[i] == 1'b0) return i;
    return -1;
  endfunction

  // Samples the middle of each data bit of a frame whose start bit begins at s.
  function automatic logic [W-1:0] decode(int s);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      int j;
      j = s + CPB * (i + 1) + CPB / 2;
      if (j >= 0 && j < TN) w[i] = trc[j];
    end
    return w;
  endfunction

  // One clock: drive inputs, take the edge, update the model, return at the falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, output logic acc);
    logic rdy;
    int s;
    din_valid = v;
    din       = d;
    rdy       = (m_count(ecur) < D);
    @(posedge clk);
    ecur++;
    acc = v && rdy && rst_n;
    if (acc) begin
      s = (ecur + 2 > last_s + FL) ? ecur + 2 : last_s + FL;
      pe.push_back(ecur);
      fs.push_back(s);
      fd.push_back(d);
      last_s = s;
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic acc;
    rst_n = 1'b1; din_valid = 1'b0; din = '0;
    clear_model();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1)      begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (count !== 3'd0)   begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (din_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", din_ready); end
    repeat (2) step(1'b0, '0, acc);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic acc, bprev;
    int t0, first, rise, fall;
    clr_trc();
    t0 = ecur + 1; rise = -1; fall = -1; bprev = busy;
    for (int c = 0; c < 86; c++) begin
      step(c == 0, 16'h0041, acc);
      if (c == 0) begin
        tests++; if (acc !== 1'b1) begin fails++; $display("FAIL single_accept got %b want 1", acc); end
      end
      tests++;
      if ({tx, busy, din_ready, count} !== m_vec(ecur)) begin
        fails++; $display("FAIL single_vec edge %0d got %b want %b", ecur - t0, {tx, busy, din_ready, count}, m_vec(ecur));
      end
      trc[ecur - t0] = tx;
      if (!bprev && busy && rise < 0) rise = ecur - t0;
      if (bprev && !busy && fall < 0) fall = ecur - t0;
      bprev = busy;
    end
    first = find_low(0);
    tests++; if (first != 2)  begin fails++; $display("FAIL single_start_edge got %0d want 2", first); end
    tests++; if (decode(first) !== 16'h0041) begin fails++; $display("FAIL single_data got %h want 0041", decode(first)); end
    tests++; if (find_low(first + CPB * (W + 1)) != -1) begin fails++; $display("FAIL single_stop low at %0d want none", find_low(first + CPB * (W + 1))); end
    tests++; if (rise != 2)   begin fails++; $display("FAIL single_busy_rise got %0d want 2", rise); end
    tests++; if (fall != 74)  begin fails++; $display("FAIL single_busy_fall got %0d want 74", fall); end
  endtask

  task automatic test_back_to_back();
    logic acc, bprev;
    int t0, first, second, bcyc, rises;
    clr_trc();
    t0 = ecur + 1; bcyc = 0; rises = 0; bprev = busy;
    for (int c = 0; c < 170; c++) begin
      step(c < 2, (c == 0) ? 16'h0048 : 16'h0069, acc);
      tests++;
      if ({tx, busy, din_ready, count} !== m_vec(ecur)) begin
        fails++; $display("FAIL b2b_vec edge %0d got %b want %b", ecur - t0, {tx, busy, din_ready, count}, m_vec(ecur));
      end
      trc[ecur - t0] = tx;
      if (busy) bcyc++;
      if (!bprev && busy) rises++;
      bprev = busy;
    end
    first  = find_low(0);
    second = find_low(first + FL - CPB);
    tests++; if (second - first != 72) begin fails++; $display("FAIL b2b_spacing got %0d want 72", second - first); end
    tests++; if (decode(first) !== 16'h0048)  begin fails++; $display("FAIL b2b_data0 got %h want 0048", decode(first)); end
    tests++; if (decode(second) !== 16'h0069) begin fails++; $display("FAIL b2b_data1 got %h want 0069", decode(second)); end
    tests++; if (bcyc != 144) begin fails++; $display("FAIL b2b_busy_cycles got %0d want 144", bcyc); end
    tests++; if (rises != 1)  begin fails++; $display("FAIL b2b_busy_gaps got %0d busy rises want 1", rises); end
  endtask

  task automatic test_backpressure();
    logic acc;
    logic [W-1:0] words [6];
    int acc_e [6];
    int t0, nxt, first, cnt4;
    foreach (words[i]) words[i] = 16'($urandom);
    clr_trc();
    t0 = ecur + 1; nxt = 0; cnt4 = -1;
    for (int c = 0; c < 460; c++) begin
      step(nxt < 6, words[(nxt < 6) ? nxt : 0], acc);
      if (acc) begin acc_e[nxt] = ecur - t0; nxt++; end
      if (ecur - t0 == 4) cnt4 = int'(count);
      tests++;
      if ({tx, busy, din_ready, count} !== m_vec(ecur)) begin
        fails++; $display("FAIL bp_vec edge %0d got %b want %b", ecur - t0, {tx, busy, din_ready, count}, m_vec(ecur));
      end
      trc[ecur - t0] = tx;
    end
    tests++; if (nxt != 6) begin fails++; $display("FAIL bp_accepted got %0d want 6", nxt); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (acc_e[i] != i) begin fails++; $display("FAIL bp_accept_edge%0d got %0d want %0d", i, acc_e[i], i); end
    end
    tests++; if (acc_e[5] != 74) begin fails++; $display("FAIL bp_accept_edge5 got %0d want 74", acc_e[5]); end
    tests++; if (cnt4 != 4) begin fails++; $display("FAIL bp_count_full got %0d want 4", cnt4); end
    first = find_low(0);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (decode(first + FL * k) !== words[k]) begin
        fails++; $display("FAIL bp_order%0d got %h want %h", k, decode(first + FL * k), words[k]);
      end
    end
  endtask

  task automatic test_push_pop();
    logic acc;
    logic [W-1:0] words [4];
    int t0, first;
    foreach (words[i]) words[i] = 16'($urandom);
    clr_trc();
    t0 = ecur + 1;
    for (int c = 0; c < 370; c++) begin
      step((c < 3) || (c == 73), words[(c < 3) ? c : 3], acc);
      if (c == 73) begin
        tests++; if (acc !== 1'b1)  begin fails++; $display("FAIL pp_accept got %b want 1", acc); end
        tests++; if (count !== 3'd2) begin fails++; $display("FAIL pp_count got %0d want 2", count); end
      end
      tests++;
      if ({tx, busy, din_ready, count} !== m_vec(ecur)) begin
        fails++; $display("FAIL pp_vec edge %0d got %b want %b", ecur - t0, {tx, busy, din_ready, count}, m_vec(ecur));
      end
      trc[ecur - t0] = tx;
    end
    first = find_low(0);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (decode(first + FL * k) !== words[k]) begin
        fails++; $display("FAIL pp_order%0d got %h want %h", k, decode(first + FL * k), words[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    logic [W-1:0] words [3];
    int t0, first;
    foreach (words[i]) words[i] = 16'($urandom);
    words[0][7] = 1'b0;  // tx is low during bit 7, so the reset visibly raises it
    t0 = ecur + 1;
    for (int c = 0; c < 36; c++) begin
      step(c < 3, words[(c < 3) ? c : 0], acc);
      tests++;
      if ({tx, busy, din_ready, count} !== m_vec(ecur)) begin
        fails++; $display("FAIL rmid_vec edge %0d got %b want %b", ecur - t0, {tx, busy, din_ready, count}, m_vec(ecur));
      end
    end
    rst_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1)      begin fails++; $display("FAIL rmid_tx got %b want 1", tx); end
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
    tests++; if (count !== 3'd0)   begin fails++; $display("FAIL rmid_count got %0d want 0", count); end
    tests++; if (din_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b want 1", din_ready); end
    clear_model();
    repeat (2) step(1'b0, '0, acc);
    rst_n = 1'b1;
    clr_trc();
    t0 = ecur + 1;
    for (int c = 0; c < 160; c++) begin
      step(c == 0, 16'h0030, acc);
      tests++;
      if ({tx, busy, din_ready, count} !== m_vec(ecur)) begin
        fails++; $display("FAIL rmid_post_vec edge %0d got %b want %b", ecur - t0, {tx, busy, din_ready, count}, m_vec(ecur));
      end
      trc[ecur - t0] = tx;
    end
    first = find_low(0);
    tests++; if (first != 2) begin fails++; $display("FAIL rmid_start_edge got %0d want 2", first); end
    tests++; if (decode(first) !== 16'h0030) begin fails++; $display("FAIL rmid_data got %h want 0030", decode(first)); end
    tests++; if (find_low(first + CPB * (W + 1)) != -1) begin fails++; $display("FAIL rmid_leftover low at %0d want none", find_low(first + CPB * (W + 1))); end
  endtask

  task automatic test_random();
    logic acc, v;
    for (int c = 0; c < 1100; c++) begin
      if (c < 450)      v = ($urandom_range(0, 3) != 0);
      else if (c < 700) v = ($urandom_range(0, 9) == 0);
      else              v = 1'b0;
      step(v, 16'($urandom), acc);
      tests++;
      if ({tx, busy, din_ready, count} !== m_vec(ecur)) begin
        fails++; $display("FAIL rand_vec edge %0d got %b want %b", ecur, {tx, busy, din_ready, count}, m_vec(ecur));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
